// File: rtl/toggle_hs_pkg.sv
// toggle_hs_pkg: FSM state encoding and synchroniser depth limits shared by the toggle handshake RX/TX pair.
package toggle_hs_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_VALID = 1'b1;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: reset-to-0 multi-flop synchroniser for a single-bit level signal.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge CLK)
    if (!RST) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/toggle_hs_rx.sv
// toggle_hs_rx: 2-phase handshake receiver presenting each toggle-announced word on a valid/ready port.
// Define TOGGLE_HS_RX_ERR_EN to add the sticky ERR protocol-violation output.
module toggle_hs_rx
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_TGL,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              ACK_TGL
`ifdef TOGGLE_HS_RX_ERR_EN
  ,
  output logic              ERR
`endif
);
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  logic              req_s, evt;
  logic              state_q, state_d;
  logic              req_seen_q, req_seen_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  sync_ff_chain #(.STAGES(STAGES)) u_req_sync (
    .CLK(CLK),
    .RST(RST),
    .d_i(REQ_TGL),
    .q_o(req_s)
  );
  assign evt = req_s != req_seen_q;
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    data_d     = data_q;
    if (state_q == ST_IDLE) begin
      if (evt) begin
        data_d     = DATA_IN;
        req_seen_d = req_s;
        state_d    = ST_VALID;
      end
    end else if (OUT_READY) begin
      ack_d   = ~ack_q;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge CLK)
    if (!RST) begin
      state_q    <= ST_IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
    end
  assign OUT_VALID = state_q == ST_VALID;
  assign OUT_DATA  = data_q;
  assign ACK_TGL   = ack_q;
`ifdef TOGGLE_HS_RX_ERR_EN
  // In VALID req_seen still holds the captured level, so any evt is a premature toggle.
  logic err_q, err_d;
  assign err_d = err_q | (state_q == ST_VALID && evt);
  always_ff @(posedge CLK)
    if (!RST) err_q <= 1'b0;
    else err_q <= err_d;
  assign ERR = err_q;
`endif
endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb_toggle_hs_rx: randomized self-checking bench for toggle_hs_rx with a queue-based sender/receiver model.
module tb_toggle_hs_rx;
  localparam int DW = 8;
  localparam int SS = 2;
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ_TGL = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic          ACK_TGL;
`ifdef TOGGLE_HS_RX_ERR_EN
  logic          ERR;
`endif
  int checks = 0;
  int failures = 0;

  toggle_hs_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_TGL(REQ_TGL),
    .DATA_IN(DATA_IN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA),
    .ACK_TGL(ACK_TGL)
`ifdef TOGGLE_HS_RX_ERR_EN
    ,
    .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic do_reset(input logic req);
    @(negedge CLK);
    RST = 1'b0;
    REQ_TGL = req;
    OUT_READY = 1'b0;
    DATA_IN = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !OUT_VALID; i++) @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout valid=%b exp=1", name, OUT_VALID);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST = 1'b0;
    REQ_TGL = 1'b1;
    DATA_IN = 8'h77;
    OUT_READY = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_DATA, ACK_TGL} !== {1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h a=%b exp v=0 d=00 a=0", OUT_VALID, OUT_DATA, ACK_TGL);
    end
    RST = 1'b1;
    wait_valid("reset_release");
    checks++;
    if (OUT_DATA !== 8'h77) begin
      failures++;
      $display("FAIL reset_release_data got=%h exp=77", OUT_DATA);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if ({OUT_VALID, ACK_TGL} !== 2'b01) begin
      failures++;
      $display("FAIL reset_release_ack got v=%b a=%b exp v=0 a=1", OUT_VALID, ACK_TGL);
    end
  endtask

  task automatic test_single;
    do_reset(1'b0);
    @(negedge CLK);
    DATA_IN = 8'hA5;
    REQ_TGL = 1'b1;
    OUT_READY = 1'b1;
    for (int n = 0; n <= SS + 1; n++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== (n == SS) || ACK_TGL !== (n > SS)) begin
        failures++;
        $display("FAIL single_timing edge=%0d got v=%b a=%b exp v=%b a=%b", n, OUT_VALID, ACK_TGL, n == SS, n > SS);
      end
      if (n == SS) begin
        checks++;
        if (OUT_DATA !== 8'hA5) begin
          failures++;
          $display("FAIL single_data got=%h exp=a5", OUT_DATA);
        end
      end
    end
    OUT_READY = 1'b0;
  endtask

  task automatic test_backpressure;
    DATA_IN = 8'h3C;
    REQ_TGL = 1'b0;
    OUT_READY = 1'b0;
    wait_valid("bp");
    repeat (10) begin
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, OUT_DATA, ACK_TGL} !== {1'b1, 8'h3C, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold got v=%b d=%h a=%b exp v=1 d=3c a=1", OUT_VALID, OUT_DATA, ACK_TGL);
      end
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if ({OUT_VALID, ACK_TGL} !== 2'b00) begin
      failures++;
      $display("FAIL bp_release got v=%b a=%b exp v=0 a=0", OUT_VALID, ACK_TGL);
    end
  endtask

  task automatic test_stream;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] front;
    logic          r;
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    do_reset(1'b0);
    while (rcv < 16 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      r = 1'($urandom_range(0, 1));
      OUT_READY = r;
      if (OUT_VALID) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_spurious got v=1 exp v=0 cycle=%0d", cyc);
        end else if (r) begin
          front = exp_q.pop_front();
          rcv++;
          if (OUT_DATA !== front) begin
            failures++;
            $display("FAIL stream_data got=%h exp=%h", OUT_DATA, front);
          end
        end
      end
      if (REQ_TGL == ACK_TGL && sent < 16 && $urandom_range(0, 2) != 0) begin
        DATA_IN = DW'(sent + 1);
        REQ_TGL = ~REQ_TGL;
        exp_q.push_back(DW'(sent + 1));
        sent++;
      end
    end
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if (rcv != 16 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=16 left=%0d", rcv, exp_q.size());
    end
    checks++;
    if ({ACK_TGL, OUT_VALID} !== 2'b00) begin
      failures++;
      $display("FAIL stream_end got a=%b v=%b exp a=0 v=0", ACK_TGL, OUT_VALID);
    end
`ifdef TOGGLE_HS_RX_ERR_EN
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL stream_err got=%b exp=0", ERR);
    end
`endif
  endtask

`ifdef TOGGLE_HS_RX_ERR_EN
  task automatic test_violation;
    do_reset(1'b0);
    @(negedge CLK);
    DATA_IN = 8'h5A;
    REQ_TGL = 1'b1;
    wait_valid("viol");
    REQ_TGL = 1'b0;
    repeat (6) @(negedge CLK);
    checks++;
    if ({ERR, OUT_VALID, OUT_DATA} !== {1'b1, 1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL viol_err got e=%b v=%b d=%h exp e=1 v=1 d=5a", ERR, OUT_VALID, OUT_DATA);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if ({ERR, ACK_TGL} !== 2'b11) begin
      failures++;
      $display("FAIL viol_sticky got e=%b a=%b exp e=1 a=1", ERR, ACK_TGL);
    end
  endtask
`endif

  task automatic test_midreset;
    do_reset(1'b0);
    @(negedge CLK);
    DATA_IN = 8'hC3;
    REQ_TGL = 1'b1;
    wait_valid("midrst");
    RST = 1'b0;
    REQ_TGL = 1'b0;
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, ACK_TGL, OUT_DATA} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL midrst_clear got v=%b a=%b d=%h exp v=0 a=0 d=00", OUT_VALID, ACK_TGL, OUT_DATA);
    end
    RST = 1'b1;
    OUT_READY = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, ACK_TGL} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_quiet got v=%b a=%b exp v=0 a=0", OUT_VALID, ACK_TGL);
      end
    end
    OUT_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
`ifdef TOGGLE_HS_RX_ERR_EN
    test_violation();
`endif
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
